// File: rtl/nd_1to2_pkg.sv
`default_nettype none
// ============================================================================
// Module : nd_1to2_pkg
// Brief  : Shared channel widths, on/off levels and FSM state encodings for
//          the 1-to-2 routing node and its synchroniser.
// Rev    : 1.0  initial release
// ============================================================================
// Contents:
//   NS_ADDRESS_SIZE / NS_DATA_SIZE / NS_REDUN_SIZE : default channel widths
//   NS_ON / NS_OFF                                  : handshake line levels
//   rx_state_e                                      : receive FSM states
//   tx_state_e                                      : send FSM states
// ============================================================================
package nd_1to2_pkg;

    // Default channel field widths used by every node of the test topology.
    localparam int NS_ADDRESS_SIZE = 8;
    localparam int NS_DATA_SIZE    = 16;
    localparam int NS_REDUN_SIZE   = 4;

    // Handshake line levels.
    localparam logic NS_ON  = 1'b1;
    localparam logic NS_OFF = 1'b0;

    // Receive side: wait for a request, then hold the ack until it is released.
    typedef enum logic [0:0] {
        RX_IDLE = 1'b0,
        RX_HOLD = 1'b1
    } rx_state_e;

    // Send side: raise req, wait for ack, wait for ack release.
    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_REQ  = 2'd1,
        TX_REL  = 2'd2
    } tx_state_e;

endpackage : nd_1to2_pkg
`default_nettype wire

// File: rtl/nd_1to2_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module : sync_2ff
// Brief  : One-bit double-flop synchroniser with asynchronous active-high
//          reset. Brings a handshake line from an unrelated clock domain into
//          the local clock domain.
// Rev    : 1.0  initial release
// ============================================================================
// Ports:
//   clk_i : local clock
//   rst_i : asynchronous active-high reset (both flops clear to 0)
//   d_i   : asynchronous input line
//   q_o   : synchronised output, two clock edges behind d_i
// ============================================================================
module sync_2ff
    import nd_1to2_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;   // first stage, may go metastable
    logic sync_q;   // second stage, safe to consume

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= NS_OFF;
            sync_q <= NS_OFF;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/nd_1to2.sv
`default_nettype none
// ============================================================================
// Module : nd_1to2
// Brief  : Two-output routing node. Accepts one four-phase req/ack channel,
//          buffers each message in a single-entry register and re-issues it
//          on snd0 (dst < SPLIT_ADDR) or snd1 (dst >= SPLIT_ADDR). Messages
//          whose destination lies outside [MIN_ADDR, MAX_ADDR] are
//          acknowledged but dropped, raising the sticky err flag.
// Rev    : 1.0  initial release
// ============================================================================
// Parameters:
//   ASZ, DSZ, RSZ : address, data and redundancy widths
//   MIN_ADDR      : lowest legal destination
//   MAX_ADDR      : highest legal destination
//   SPLIT_ADDR    : first destination routed to snd1
// Ports:
//   i_clk, reset                     : clock, async active-high reset
//   ready                            : node operational
//   rcv0_src/dst/dat/red, rcv0_req   : inbound message and request
//   rcv0_ack                         : inbound acknowledge
//   snd0_src/dst/dat/red, snd0_req   : outbound message and request, port 0
//   snd0_ack                         : outbound acknowledge, port 0
//   snd1_*                           : same as snd0_*, port 1
//   err                              : sticky out-of-range drop flag
// ============================================================================
module nd_1to2
    import nd_1to2_pkg::*;
#(
    parameter int ASZ        = NS_ADDRESS_SIZE,
    parameter int DSZ        = NS_DATA_SIZE,
    parameter int RSZ        = NS_REDUN_SIZE,
    parameter int MIN_ADDR   = 0,
    parameter int MAX_ADDR   = 55,
    parameter int SPLIT_ADDR = 28
) (
    input  logic           i_clk,
    input  logic           reset,
    output logic           ready,

    input  logic [ASZ-1:0] rcv0_src,
    input  logic [ASZ-1:0] rcv0_dst,
    input  logic [DSZ-1:0] rcv0_dat,
    input  logic [RSZ-1:0] rcv0_red,
    input  logic           rcv0_req,
    output logic           rcv0_ack,

    output logic [ASZ-1:0] snd0_src,
    output logic [ASZ-1:0] snd0_dst,
    output logic [DSZ-1:0] snd0_dat,
    output logic [RSZ-1:0] snd0_red,
    output logic           snd0_req,
    input  logic           snd0_ack,

    output logic [ASZ-1:0] snd1_src,
    output logic [ASZ-1:0] snd1_dst,
    output logic [DSZ-1:0] snd1_dat,
    output logic [RSZ-1:0] snd1_red,
    output logic           snd1_req,
    input  logic           snd1_ack,

    output logic           err
);

    // ------------------------------------------------------------------
    // Address bounds, widened by one bit so that every range test below is
    // an unsigned subtraction whose borrow gives the answer. This keeps the
    // tests well defined even when a bound is 0 or equals 2**ASZ.
    // ------------------------------------------------------------------
    localparam logic [ASZ:0] c_MIN_ADDR   = (ASZ+1)'(MIN_ADDR);
    localparam logic [ASZ:0] c_ABOVE_MAX  = (ASZ+1)'(MAX_ADDR + 1);
    localparam logic [ASZ:0] c_SPLIT_ADDR = (ASZ+1)'(SPLIT_ADDR);

    // Unsigned a >= b, evaluated as "no borrow out of a - b".
    function automatic logic addr_ge(input logic [ASZ-1:0] a,
                                     input logic [ASZ:0]   b);
        logic [ASZ:0] diff;
        diff = {1'b0, a} - b;
        return ~diff[ASZ];
    endfunction

    // ------------------------------------------------------------------
    // Synchronisers: the FSMs only ever look at these versions.
    // ------------------------------------------------------------------
    logic req_s;
    logic ack0_s;
    logic ack1_s;

    sync_2ff u_sync_req (
        .clk_i (i_clk),
        .rst_i (reset),
        .d_i   (rcv0_req),
        .q_o   (req_s)
    );

    sync_2ff u_sync_ack0 (
        .clk_i (i_clk),
        .rst_i (reset),
        .d_i   (snd0_ack),
        .q_o   (ack0_s)
    );

    sync_2ff u_sync_ack1 (
        .clk_i (i_clk),
        .rst_i (reset),
        .d_i   (snd1_ack),
        .q_o   (ack1_s)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    rx_state_e      rx_state_q;
    tx_state_e      tx_state_q;

    logic [ASZ-1:0] buf_src_q;
    logic [ASZ-1:0] buf_dst_q;
    logic [DSZ-1:0] buf_dat_q;
    logic [RSZ-1:0] buf_red_q;
    logic           full_q;     // buffer holds a message not yet delivered
    logic           sel_q;      // 0: snd0, 1: snd1

    logic           ready_q;
    logic           rcv_ack_q;
    logic           snd0_req_q;
    logic           snd1_req_q;
    logic           err_q;

    // ------------------------------------------------------------------
    // Destination classification of the inbound message
    // ------------------------------------------------------------------
    logic dst_legal;
    logic dst_hi;
    logic ack_sel_s;

    assign dst_legal = addr_ge(rcv0_dst, c_MIN_ADDR) &
                       ~addr_ge(rcv0_dst, c_ABOVE_MAX);
    assign dst_hi    = addr_ge(rcv0_dst, c_SPLIT_ADDR);

    // Only the selected port's acknowledge matters; the other is ignored.
    assign ack_sel_s = sel_q ? ack1_s : ack0_s;

    // ------------------------------------------------------------------
    // Receive and send FSMs.
    // Both live in one block because they share the buffer-full flag: the
    // receive side sets it, the send side clears it. The two never act on it
    // in the same cycle, since capture requires full_q == 0 while the clear
    // happens only in TX_REL with full_q == 1. A message arriving right as
    // the buffer clears is therefore captured one edge later.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            rx_state_q <= RX_IDLE;
            tx_state_q <= TX_IDLE;
            buf_src_q  <= '0;
            buf_dst_q  <= '0;
            buf_dat_q  <= '0;
            buf_red_q  <= '0;
            full_q     <= NS_OFF;
            sel_q      <= NS_OFF;
            ready_q    <= NS_OFF;
            rcv_ack_q  <= NS_OFF;
            snd0_req_q <= NS_OFF;
            snd1_req_q <= NS_OFF;
            err_q      <= NS_OFF;
        end else begin
            ready_q <= NS_ON;

            // ---------------- receive side ----------------
            case (rx_state_q)
                RX_IDLE: begin
                    // A request arriving while the buffer is occupied is left
                    // pending (ack stays low) until the send side drains it.
                    if (req_s && !full_q) begin
                        rcv_ack_q  <= NS_ON;
                        rx_state_q <= RX_HOLD;
                        if (dst_legal) begin
                            buf_src_q <= rcv0_src;
                            buf_dst_q <= rcv0_dst;
                            buf_dat_q <= rcv0_dat;
                            buf_red_q <= rcv0_red;
                            sel_q     <= dst_hi;
                            full_q    <= NS_ON;
                        end else begin
                            // Acknowledged normally, but never forwarded.
                            err_q <= NS_ON;
                        end
                    end
                end
                RX_HOLD: begin
                    if (!req_s) begin
                        rcv_ack_q  <= NS_OFF;
                        rx_state_q <= RX_IDLE;
                    end
                end
                default: begin
                    rcv_ack_q  <= NS_OFF;
                    rx_state_q <= RX_IDLE;
                end
            endcase

            // ---------------- send side ----------------
            case (tx_state_q)
                TX_IDLE: begin
                    if (full_q) begin
                        if (sel_q) begin
                            snd1_req_q <= NS_ON;
                        end else begin
                            snd0_req_q <= NS_ON;
                        end
                        tx_state_q <= TX_REQ;
                    end
                end
                TX_REQ: begin
                    if (ack_sel_s) begin
                        snd0_req_q <= NS_OFF;
                        snd1_req_q <= NS_OFF;
                        tx_state_q <= TX_REL;
                    end
                end
                TX_REL: begin
                    // Buffer is released only once the receiver has let go of
                    // ack, completing the four-phase cycle.
                    if (!ack_sel_s) begin
                        full_q     <= NS_OFF;
                        tx_state_q <= TX_IDLE;
                    end
                end
                default: begin
                    snd0_req_q <= NS_OFF;
                    snd1_req_q <= NS_OFF;
                    tx_state_q <= TX_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Both ports carry the buffered fields at all times; only the
    // request line is port specific. Fields are forwarded unmodified.
    // ------------------------------------------------------------------
    assign ready    = ready_q;
    assign rcv0_ack = rcv_ack_q;
    assign err      = err_q;

    assign snd0_src = buf_src_q;
    assign snd0_dst = buf_dst_q;
    assign snd0_dat = buf_dat_q;
    assign snd0_red = buf_red_q;
    assign snd0_req = snd0_req_q;

    assign snd1_src = buf_src_q;
    assign snd1_dst = buf_dst_q;
    assign snd1_dat = buf_dat_q;
    assign snd1_red = buf_red_q;
    assign snd1_req = snd1_req_q;

endmodule : nd_1to2
`default_nettype wire

// File: tb/tb_nd_1to2.sv
`default_nettype none
// ============================================================================
// Module : tb_nd_1to2
// Brief  : Self-checking bench for nd_1to2. An upstream driver pushes the
//          expected delivery of every legal message onto a per-port queue;
//          a downstream responder pops and compares when the DUT raises req.
// Rev    : 1.0  initial release
// ============================================================================
module tb_nd_1to2;

    typedef struct packed {
        logic [7:0]  src;
        logic [7:0]  dst;
        logic [15:0] dat;
        logic [3:0]  red;
    } msg_t;

    logic        clk;
    logic        reset;
    logic        ready;
    logic [7:0]  rcv0_src, rcv0_dst;
    logic [15:0] rcv0_dat;
    logic [3:0]  rcv0_red;
    logic        rcv0_req, rcv0_ack;
    logic [7:0]  snd0_src, snd0_dst, snd1_src, snd1_dst;
    logic [15:0] snd0_dat, snd1_dat;
    logic [3:0]  snd0_red, snd1_red;
    logic        snd0_req, snd0_ack, snd1_req, snd1_ack;
    logic        err;

    nd_1to2 dut (
        .i_clk    (clk),
        .reset    (reset),
        .ready    (ready),
        .rcv0_src (rcv0_src),
        .rcv0_dst (rcv0_dst),
        .rcv0_dat (rcv0_dat),
        .rcv0_red (rcv0_red),
        .rcv0_req (rcv0_req),
        .rcv0_ack (rcv0_ack),
        .snd0_src (snd0_src),
        .snd0_dst (snd0_dst),
        .snd0_dat (snd0_dat),
        .snd0_red (snd0_red),
        .snd0_req (snd0_req),
        .snd0_ack (snd0_ack),
        .snd1_src (snd1_src),
        .snd1_dst (snd1_dst),
        .snd1_dat (snd1_dat),
        .snd1_red (snd1_red),
        .snd1_req (snd1_req),
        .snd1_ack (snd1_ack),
        .err      (err)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    msg_t exp_q0[$];
    msg_t exp_q1[$];
    int   deliv[2];
    int   rel_cyc[2];
    int   resp_extra[2];
    int   r_st[2];
    int   r_cnt[2];
    bit   async_mode = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Downstream responder for both ports, sampling on the falling edge.
    // ------------------------------------------------------------------
    initial begin
        logic reqv[2];
        logic ackv[2];
        msg_t mcur;
        msg_t mexp;
        ackv[0] = 0; ackv[1] = 0;
        r_st[0] = 0; r_st[1] = 0;
        r_cnt[0] = 0; r_cnt[1] = 0;
        deliv[0] = 0; deliv[1] = 0;
        rel_cyc[0] = -1; rel_cyc[1] = -1;
        snd0_ack = 0; snd1_ack = 0;
        forever begin
            @(negedge clk);
            reqv[0] = snd0_req;
            reqv[1] = snd1_req;
            n_checks++;
            if (snd0_req && snd1_req) begin
                n_fail++;
                $display("FAIL both_req: snd0_req=%b snd1_req=%b, required at most one high", snd0_req, snd1_req);
            end
            if (reset) begin
                ackv[0] = 0; ackv[1] = 0;
                r_st[0] = 0; r_st[1] = 0;
            end else begin
                for (int p = 0; p < 2; p++) begin
                    case (r_st[p])
                        0: if (reqv[p]) begin
                            mcur = (p == 0) ? {snd0_src, snd0_dst, snd0_dat, snd0_red}
                                            : {snd1_src, snd1_dst, snd1_dat, snd1_red};
                            n_checks++;
                            if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
                                n_fail++;
                                $display("FAIL unexpected_req port%0d: got dst=%0d dat=%h, required no request", p, mcur.dst, mcur.dat);
                            end else begin
                                mexp = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                                if (mcur !== mexp) begin
                                    n_fail++;
                                    $display("FAIL deliver port%0d: got src=%h dst=%h dat=%h red=%h, required src=%h dst=%h dat=%h red=%h",
                                             p, mcur.src, mcur.dst, mcur.dat, mcur.red, mexp.src, mexp.dst, mexp.dat, mexp.red);
                                end
                            end
                            deliv[p]++;
                            r_cnt[p] = 2 + resp_extra[p];
                            r_st[p]  = 1;
                        end
                        1: begin
                            if (r_cnt[p] > 0) r_cnt[p]--;
                            else if (!async_mode || (cyc % 7) == 0) begin
                                ackv[p] = 1;
                                r_st[p] = 2;
                            end
                        end
                        2: if (!reqv[p] && (!async_mode || (cyc % 7) == 0)) begin
                            ackv[p]    = 0;
                            rel_cyc[p] = cyc;
                            r_st[p]    = 0;
                        end
                        default: r_st[p] = 0;
                    endcase
                end
            end
            snd0_ack = ackv[0];
            snd1_ack = ackv[1];
        end
    end

    // ------------------------------------------------------------------
    // Upstream driver: one four-phase transaction. Expected delivery is
    // queued when the request is raised.
    // ------------------------------------------------------------------
    task automatic send_msg(input msg_t m, output int ack_edges, output int ack_cyc);
        int n;
        @(negedge clk);
        while (async_mode && (cyc % 3) != 0) @(negedge clk);
        {rcv0_src, rcv0_dst, rcv0_dat, rcv0_red} = m;
        if (m.dst <= 8'd55) begin
            if (m.dst >= 8'd28) exp_q1.push_back(m);
            else                exp_q0.push_back(m);
        end
        rcv0_req = 1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!rcv0_ack && n < 1000);
        ack_edges = n;
        ack_cyc   = cyc;
        n_checks++;
        if (!rcv0_ack) begin
            n_fail++;
            $display("FAIL ack_rise dst=%0d: rcv0_ack=%b after %0d edges, required 1", m.dst, rcv0_ack, n);
        end
        @(negedge clk);
        while (async_mode && (cyc % 3) != 0) @(negedge clk);
        rcv0_req = 0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (rcv0_ack && n < 100);
        n_checks++;
        if (rcv0_ack) begin
            n_fail++;
            $display("FAIL ack_fall dst=%0d: rcv0_ack=%b, required 0", m.dst, rcv0_ack);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0 || r_st[0] != 0 || r_st[1] != 0 ||
                snd0_req || snd1_req) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (n >= 5000) begin
            n_fail++;
            $display("FAIL drain: pending q0=%0d q1=%0d, required 0", exp_q0.size(), exp_q1.size());
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1; rcv0_req = 0;
        rcv0_src = '0; rcv0_dst = '0; rcv0_dat = '0; rcv0_red = '0;
        resp_extra[0] = 0; resp_extra[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({ready, rcv0_ack, snd0_req, snd1_req, err, snd0_src, snd0_dst, snd0_dat, snd0_red,
             snd1_src, snd1_dst, snd1_dat, snd1_red} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b ack=%b req0=%b req1=%b err=%b dst=%h, required all 0",
                     ready, rcv0_ack, snd0_req, snd1_req, err, snd0_dst);
        end
        @(negedge clk);
        reset = 0;
        #1;
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_edge: ready=%b, required 0", ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_edge: ready=%b, required 1", ready);
        end
    endtask

    task automatic test_route_low();
        msg_t m;
        int   n;
        m = '{src: 8'h11, dst: 8'd5, dat: 16'h003C, red: 4'h9};
        @(negedge clk);
        {rcv0_src, rcv0_dst, rcv0_dat, rcv0_red} = m;
        exp_q0.push_back(m);
        rcv0_req = 1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!rcv0_ack && n < 50);
        n_checks++;
        if (n != 3 || !rcv0_ack) begin
            n_fail++;
            $display("FAIL ack_latency: ack after %0d edges (ack=%b), required 3", n, rcv0_ack);
        end
        n_checks++;
        if (snd0_dst !== 8'd5 || snd0_dat !== 16'h003C || snd0_req !== 1'b0) begin
            n_fail++;
            $display("FAIL data_before_req: dst=%0d dat=%h req=%b, required dst=5 dat=003c req=0",
                     snd0_dst, snd0_dat, snd0_req);
        end
        @(posedge clk); #1;
        n_checks++;
        if (snd0_req !== 1'b1 || snd1_req !== 1'b0) begin
            n_fail++;
            $display("FAIL req_latency: snd0_req=%b snd1_req=%b, required 1/0", snd0_req, snd1_req);
        end
        @(negedge clk);
        rcv0_req = 0;
        n = 0;
        while (rcv0_ack && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        drain();
        n_checks++;
        if (deliv[0] != 1 || deliv[1] != 0) begin
            n_fail++;
            $display("FAIL route_low_count: deliv0=%0d deliv1=%0d, required 1/0", deliv[0], deliv[1]);
        end
    endtask

    task automatic test_route_boundary();
        logic [7:0] dsts[3];
        int         ports[3];
        int         d0, d1, ae, ac;
        msg_t       m;
        dsts[0] = 8'd27; ports[0] = 0;
        dsts[1] = 8'd28; ports[1] = 1;
        dsts[2] = 8'd55; ports[2] = 1;
        for (int i = 0; i < 3; i++) begin
            d0 = deliv[0]; d1 = deliv[1];
            m = '{src: 8'(i + 3), dst: dsts[i], dat: 16'hA500 + 16'(i), red: 4'(i + 1)};
            send_msg(m, ae, ac);
            drain();
            n_checks++;
            if ((deliv[0] - d0) != (ports[i] == 0 ? 1 : 0) || (deliv[1] - d1) != (ports[i] == 1 ? 1 : 0)) begin
                n_fail++;
                $display("FAIL boundary dst=%0d: port0 +%0d port1 +%0d, required port%0d only",
                         dsts[i], deliv[0] - d0, deliv[1] - d1, ports[i]);
            end
        end
    endtask

    task automatic test_drop();
        int   d0, d1, ae, ac;
        msg_t m;
        d0 = deliv[0]; d1 = deliv[1];
        m = '{src: 8'h22, dst: 8'd60, dat: 16'hDEAD, red: 4'h3};
        send_msg(m, ae, ac);
        n_checks++;
        if (ae != 3) begin
            n_fail++;
            $display("FAIL drop_ack: ack after %0d edges, required 3", ae);
        end
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (err !== 1'b1 || deliv[0] != d0 || deliv[1] != d1 || snd0_req || snd1_req) begin
            n_fail++;
            $display("FAIL drop: err=%b new deliveries %0d/%0d, required err=1 and none",
                     err, deliv[0] - d0, deliv[1] - d1);
        end
        for (int i = 0; i < 3; i++) begin
            m = '{src: 8'h30, dst: 8'(1 + 25 * i), dat: 16'h1234 + 16'(i), red: 4'h5};
            send_msg(m, ae, ac);
            drain();
            n_checks++;
            if (err !== 1'b1) begin
                n_fail++;
                $display("FAIL err_sticky msg%0d: err=%b, required 1", i, err);
            end
        end
    endtask

    task automatic test_backpressure();
        int   ae, ac;
        msg_t ma, mb;
        ma = '{src: 8'h41, dst: 8'd3, dat: 16'hAAAA, red: 4'h1};
        mb = '{src: 8'h42, dst: 8'd4, dat: 16'hBBBB, red: 4'h2};
        resp_extra[0] = 100;
        rel_cyc[0] = -1;
        send_msg(ma, ae, ac);
        send_msg(mb, ae, ac);
        n_checks++;
        if (ae <= 90 || rel_cyc[0] < 0 || ac <= rel_cyc[0]) begin
            n_fail++;
            $display("FAIL backpressure: second ack after %0d edges at cyc %0d, first release cyc %0d, required ack after release",
                     ae, ac, rel_cyc[0]);
        end
        resp_extra[0] = 0;
        drain();
    endtask

    task automatic test_async();
        int   d0, d1, e0, e1, ae, ac;
        msg_t m;
        d0 = deliv[0]; d1 = deliv[1];
        e0 = 0; e1 = 0;
        async_mode = 1;
        for (int i = 0; i < 200; i++) begin
            m.src = 8'($urandom_range(0, 255));
            m.dst = 8'($urandom_range(0, 55));
            m.dat = 16'($urandom_range(0, 65535));
            m.red = 4'($urandom_range(0, 15));
            if (m.dst >= 8'd28) e1++;
            else                e0++;
            send_msg(m, ae, ac);
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end
        drain();
        async_mode = 0;
        n_checks++;
        if ((deliv[0] - d0) != e0 || (deliv[1] - d1) != e1) begin
            n_fail++;
            $display("FAIL async_counts: delivered %0d/%0d, required %0d/%0d",
                     deliv[0] - d0, deliv[1] - d1, e0, e1);
        end
    endtask

    task automatic test_reset_midop();
        int   n, d0, ae, ac;
        msg_t m;
        resp_extra[1] = 50;
        m = '{src: 8'h51, dst: 8'd40, dat: 16'hC0DE, red: 4'hE};
        send_msg(m, ae, ac);
        n = 0;
        while (!snd1_req && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (!snd1_req) begin
            n_fail++;
            $display("FAIL midop_req: snd1_req=%b, required 1", snd1_req);
        end
        @(negedge clk);
        reset = 1;
        #1;
        n_checks++;
        if ({ready, rcv0_ack, snd0_req, snd1_req, err, snd1_src, snd1_dst, snd1_dat, snd1_red} !== '0) begin
            n_fail++;
            $display("FAIL midop_reset_outputs: ready=%b req1=%b err=%b dst=%h, required all 0",
                     ready, snd1_req, err, snd1_dst);
        end
        resp_extra[1] = 0;
        exp_q0.delete();
        exp_q1.delete();
        repeat (3) @(negedge clk);
        reset = 0;
        @(posedge clk); #1;
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_ready: ready=%b, required 1", ready);
        end
        d0 = deliv[0];
        m = '{src: 8'h52, dst: 8'd10, dat: 16'h5A5A, red: 4'h6};
        send_msg(m, ae, ac);
        drain();
        n_checks++;
        if (deliv[0] - d0 != 1) begin
            n_fail++;
            $display("FAIL midop_next: delivered %0d on port0, required 1", deliv[0] - d0);
        end
    endtask

    initial begin
        test_reset();
        test_route_low();
        test_route_boundary();
        test_drop();
        test_backpressure();
        test_async();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_nd_1to2
`default_nettype wire

// File: doc/nd_1to2.md
# nd_1to2

Two-output routing node that consumes the single output channel of `nd_2to1` and steers each message, by destination address, to one of two send channels. It completes the 2→1→2 merge/split test topology. Each incoming four-phase req/ack transaction is buffered in a single-entry register and re-issued on `snd0` or `snd1`. Because neighbouring stages run on unrelated debug clocks, all incoming `req`/`ack` lines are double-flop synchronised.

## Interface
- `ASZ`, default `` `NS_ADDRESS_SIZE ``: address width.
- `DSZ`, default `` `NS_DATA_SIZE ``: data width.
- `RSZ`, default `` `NS_REDUN_SIZE ``: redundancy width.
- `MIN_ADDR`, default 0: lowest legal destination.
- `MAX_ADDR`, default 55: highest legal destination.
- `SPLIT_ADDR`, default 28: destinations below this go to `snd0`; destinations at or above it go to `snd1`.
- `i_clk`  in  1  sole clock; the single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `ready`  out  1  node operational.
- `rcv0_src`, `rcv0_dst`  in  ASZ  source and destination address.
- `rcv0_dat`  in  DSZ  payload.
- `rcv0_red`  in  RSZ  redundancy.
- `rcv0_req`  in  1  request from upstream.
- `rcv0_ack`  out  1  acknowledge to upstream.
- `snd0_src`, `snd0_dst`  out  ASZ  forwarded addresses.
- `snd0_dat`  out  DSZ  forwarded payload.
- `snd0_red`  out  RSZ  forwarded redundancy.
- `snd0_req`  out  1  request to downstream.
- `snd0_ack`  in  1  acknowledge from downstream.
- `snd1_*`  same widths and directions as `snd0_*`.
- `err`  out  1  sticky flag: a message with an out-of-range destination was dropped.

## Operation
**Reset values**
- All outputs are 0 while `reset` is high: `ready`, `rcv0_ack`, `snd0_req`, `snd1_req`, `err`, and all data fields.
- Buffer is empty.
- Both FSMs are in IDLE.
- `ready` goes to 1 on the first `i_clk` edge after `reset` falls.

**Synchroniser**
- `rcv0_req`, `snd0_ack` and `snd1_ack` each pass through two flops.
- The FSMs see only the synchronised versions: `req_s`, `ack0_s`, `ack1_s`.

**Receive FSM**
- IDLE: when `req_s`=1 and the buffer is empty:
  - capture src/dst/dat/red;
  - set `rcv0_ack`=1;
  - go to HOLD.
- HOLD: when `req_s`=0, set `rcv0_ack`=0 and go to IDLE.
- Capture check: if `dst` < `MIN_ADDR` or `dst` > `MAX_ADDR`, the message is acknowledged normally but not buffered, and `err` is set to 1. `err` is cleared only by reset.
- Otherwise the buffer becomes full, with `sel` = (`dst` ≥ `SPLIT_ADDR`).
- Compare widths: comparisons are unsigned, ASZ bits.

**Send FSM**
- IDLE: when the buffer is full, set `snd[sel]_req`=1 and go to REQ.
- REQ: when `ack[sel]_s`=1, set `snd[sel]_req`=0 and go to REL.
- REL: when `ack[sel]_s`=0, clear the buffer and go to IDLE.
- Both ports' data outputs are driven from the buffer register at all times. Only `req` is port-specific.
- The unselected port's `req` stays 0. The unselected port's `ack` is ignored.
- Fields are forwarded unmodified. The redundancy field is not recomputed.

## Timing
- Input-to-FSM synchroniser latency: 2 cycles.
- `rcv0_req` rise → `rcv0_ack` rise: 3 edges (2 sync + capture).
- Capture edge → `snd[sel]_req` rise: 1 edge. Data is stable from the capture edge, i.e. one cycle before `req`.
- Back-to-back messages: the buffer-clear edge and a new capture never coincide. Capture tests the registered empty flag, so the earliest next capture is 1 edge after the clear.
- Upstream `req` held high while the buffer is full: the receive FSM stays in IDLE and `ack` stays low until the buffer empties.
- Reset mid-transaction:
  - all `req`/`ack` outputs drop asynchronously;
  - the buffered message is lost;
  - neighbours must restart their handshake.
- Throughput: at most one message per full four-phase cycle on each side. The receive handshake of the next message overlaps the send handshake of the current one.

## Structure
- Channel field widths and `` `NS_ON ``/`` `NS_OFF `` come from `hglobal.v`.
- Add `` `NS_DECLARE_SPLIT_LINKS `` to `hglobal.v` so test tops can declare both output links.
- Sub-module `sync_2ff`, a one-bit double-flop synchroniser with async reset. It is instantiated three times.

## Test plan
- **Route low:** send dst=5, dat=0x3C → `snd0` carries dst=5, dat=0x3C; `snd1_req` stays 0; `rcv0_ack` rises exactly 3 edges after `req`.
- **Route high/boundary:** dst=27 → `snd0`; dst=28 → `snd1`; dst=55 → `snd1`.
- **Drop:** dst=60 → `rcv0_ack` completes the handshake; neither `snd*_req` rises; `err`=1 and stays 1 through 3 further legal messages.
- **Backpressure:** hold `snd0_ack` low for 100 cycles with a second message pending → second `rcv0_ack` stays 0 until the first `snd0` handshake ends. Both messages are delivered in order.
- **Async clocks:** drive upstream and downstream on 3- and 7-cycle derived clocks, 200 random messages (dst 0–55) → no loss, no duplication, correct port per message.
- **Reset mid-op:** assert `reset` while `snd1_req`=1 → all outputs 0 in the same cycle; `ready` returns 1 one edge after release; the next message routes correctly.
